// File: rtl/param_sync_fifo.sv
// param_sync_fifo
// Single-clock FIFO with arbitrary (non power-of-two) depth.
// Features: programmable almost-full/almost-empty thresholds, an occupancy
// count, sticky overflow/underflow flags, synchronous flush, and a
// selectable first-word-fall-through read mode.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   wr_en_i         write request, wdata_i carries the word
//   rd_en_i         read request (pop)
//   flush_i         synchronous clear of pointers and count
//   clr_err_i       synchronous clear of the sticky error flags
//   rdata_o         read data, qualified by rd_valid_o
//   full_o, empty_o, almost_full_o, almost_empty_o   status derived from count
//   count_o         occupancy, 0..DEPTH
//   overflow_o      sticky: write rejected because FIFO full
//   underflow_o     sticky: read rejected because FIFO empty
module param_sync_fifo #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter int FWFT      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en_i,
   input  logic [WIDTH-1:0]             wdata_i,
   input  logic                         rd_en_i,
   input  logic                         flush_i,
   input  logic                         clr_err_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         rd_valid_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic                         almost_full_o,
   output logic                         almost_empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         overflow_o,
   output logic                         underflow_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   if (WIDTH < 1 || DEPTH < 2 || AE_THRESH < 1 || AE_THRESH >= AF_THRESH ||
       AF_THRESH > DEPTH || (FWFT != 0 && FWFT != 1)) begin : g_bad_params
      $error("param_sync_fifo: illegal parameter combination");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             rd_accept, wr_accept;
   logic             ovf_set, udf_set;

   assign full_o         = (count_q == CW'(DEPTH));
   assign empty_o        = (count_q == '0);
   assign almost_full_o  = (count_q >= CW'(AF_THRESH));
   assign almost_empty_o = (count_q <= CW'(AE_THRESH));
   assign count_o        = count_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

   // flush masks every access, so neither data movement nor errors happen on it.
   assign rd_accept = rd_en_i && !empty_o && !flush_i;
   assign wr_accept = wr_en_i && (!full_o || rd_accept) && !flush_i;
   assign ovf_set   = wr_en_i && full_o && !rd_accept && !flush_i;
   assign udf_set   = rd_en_i && empty_o && !flush_i;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = ovf_set ? 1'b1 : (clr_err_i ? 1'b0 : overflow_q);
      underflow_d = udf_set ? 1'b1 : (clr_err_i ? 1'b0 : underflow_q);
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         // Explicit wrap: DEPTH need not be a power of two.
         if (wr_accept) wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
         if (rd_accept) rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
         if (wr_accept && !rd_accept)      count_d = count_q + CW'(1);
         else if (rd_accept && !wr_accept) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Array is cleared on reset so the FWFT output reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_accept) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   if (FWFT == 0) begin : g_std_read
      logic [WIDTH-1:0] rdata_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            if (rd_accept) rdata_q <= mem_q[rptr_q];
            rd_valid_q <= rd_accept;
         end
      end

      assign rdata_o    = rdata_q;
      assign rd_valid_o = rd_valid_q;
   end else begin : g_fwft_read
      assign rdata_o    = mem_q[rptr_q];
      assign rd_valid_o = !empty_o;
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;
   localparam int WIDTH = 4;
   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst_n;
   logic wr_en, rd_en, flush, clr_err;
   logic [WIDTH-1:0] wdata;

   logic [WIDTH-1:0] rdata0, rdata1;
   logic rvld0, rvld1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
   logic [CW-1:0] cnt0, cnt1;
   logic ovf0, ovf1, udf0, udf1;

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of stored words plus the visible read register.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_rdata;
   logic             m_rvalid, m_ovf, m_udf;

   always #5 clk = ~clk;

   param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
      .flush_i(flush), .clr_err_i(clr_err), .rdata_o(rdata0), .rd_valid_o(rvld0),
      .full_o(full0), .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0),
      .count_o(cnt0), .overflow_o(ovf0), .underflow_o(udf0));

   param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
      .flush_i(flush), .clr_err_i(clr_err), .rdata_o(rdata1), .rd_valid_o(rvld1),
      .full_o(full1), .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1),
      .count_o(cnt1), .overflow_o(ovf1), .underflow_o(udf1));

   task automatic model_reset();
      q.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
   endtask

   // One clock: drive at the falling edge, update the model at the rising
   // edge, return at the next falling edge with inputs released.
   task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic f, input logic c);
      int  n;
      bit  ra, wa, os, us;
      wr_en = w; wdata = d; rd_en = r; flush = f; clr_err = c;
      @(posedge clk);
      n  = q.size();
      ra = r && n > 0 && !f;
      wa = w && (n < DEPTH || ra) && !f;
      os = w && !f && n == DEPTH && !ra;
      us = r && !f && n == 0;
      if (f) begin
         q.delete();
         m_rvalid = 1'b0;
      end else begin
         if (ra) m_rdata = q.pop_front();
         m_rvalid = ra;
         if (wa) q.push_back(d);
      end
      m_ovf = os ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = us ? 1'b1 : (c ? 1'b0 : m_udf);
      @(negedge clk);
      wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      checks++; if (cnt0 !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
      checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin errors++; $display("FAIL reset_flags: got e/f/ae/af=%b expected 1010", {empty0, full0, ae0, af0}); end
      checks++; if ({rvld0, ovf0, udf0} !== 3'b000) begin errors++; $display("FAIL reset_valid_err: got %b expected 000", {rvld0, ovf0, udf0}); end
      checks++; if (rdata0 !== 4'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata0); end
      checks++; if ({rvld1, rdata1, empty1} !== {1'b0, 4'h0, 1'b1}) begin errors++; $display("FAIL reset_fwft: got vld=%b data=%h empty=%b expected 0 0 1", rvld1, rdata1, empty1); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 4'(i), 0, 0, 0);
         checks++; if (cnt0 !== CW'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", cnt0, i); end
         checks++; if (af0 !== (i >= 4)) begin errors++; $display("FAIL fill_af: count %0d got %b expected %b", i, af0, i >= 4); end
         checks++; if (full0 !== (i == 5)) begin errors++; $display("FAIL fill_full: count %0d got %b expected %b", i, full0, i == 5); end
      end
      cyc(1, 4'hF, 0, 0, 0);
      checks++; if ({ovf0, cnt0} !== {1'b1, CW'(5)}) begin errors++; $display("FAIL overflow: got ovf=%b count=%0d expected 1 5", ovf0, cnt0); end
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 1, 0, 0);
         checks++; if ({rvld0, rdata0} !== {1'b1, 4'(i)}) begin errors++; $display("FAIL drain_data: got vld=%b data=%h expected 1 %h", rvld0, rdata0, i); end
      end
      checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty0); end
      cyc(0, 0, 1, 0, 0);
      checks++; if ({udf0, rvld0} !== 2'b10) begin errors++; $display("FAIL underflow: got udf=%b vld=%b expected 1 0", udf0, rvld0); end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] base, sent [3];
      cyc(0, 0, 0, 0, 1);
      base = 4'($urandom);
      for (int rnd = 0; rnd < 4; rnd++) begin
         for (int k = 0; k < 3; k++) begin
            sent[k] = base;
            cyc(1, base, 0, 0, 0);
            base = base + 4'd1;
         end
         checks++; if (cnt0 !== CW'(3)) begin errors++; $display("FAIL wrap_count_full: round %0d got %0d expected 3", rnd, cnt0); end
         for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 0);
            checks++; if ({rvld0, rdata0} !== {1'b1, sent[k]}) begin errors++; $display("FAIL wrap_data: round %0d got %b/%h expected 1/%h", rnd, rvld0, rdata0, sent[k]); end
         end
         checks++; if (cnt0 !== 0) begin errors++; $display("FAIL wrap_count_zero: round %0d got %0d expected 0", rnd, cnt0); end
      end
   endtask

   task automatic test_simultaneous();
      logic [WIDTH-1:0] v [5];
      logic [WIDTH-1:0] exp;
      for (int i = 0; i < 5; i++) begin
         v[i] = 4'($urandom);
         cyc(1, v[i], 0, 0, 0);
      end
      cyc(1, 4'h9, 1, 0, 0);
      checks++; if ({cnt0, full0, ovf0} !== {CW'(5), 1'b1, 1'b0}) begin errors++; $display("FAIL sim_full_count: got count=%0d full=%b ovf=%b expected 5 1 0", cnt0, full0, ovf0); end
      checks++; if ({rvld0, rdata0} !== {1'b1, v[0]}) begin errors++; $display("FAIL sim_full_oldest: got %b/%h expected 1/%h", rvld0, rdata0, v[0]); end
      for (int i = 1; i <= 5; i++) begin
         exp = (i == 5) ? 4'h9 : v[i];
         cyc(0, 0, 1, 0, 0);
         checks++; if (rdata0 !== exp) begin errors++; $display("FAIL sim_full_order: read %0d got %h expected %h", i, rdata0, exp); end
      end
      cyc(1, 4'h6, 1, 0, 0);
      checks++; if ({cnt0, rvld0, udf0} !== {CW'(1), 1'b0, 1'b1}) begin errors++; $display("FAIL sim_empty: got count=%0d vld=%b udf=%b expected 1 0 1", cnt0, rvld0, udf0); end
      checks++; if ({rvld1, rdata1} !== {1'b1, 4'h6}) begin errors++; $display("FAIL sim_empty_fwft: got %b/%h expected 1/6", rvld1, rdata1); end
      cyc(0, 0, 1, 0, 0);
   endtask

   task automatic test_flush_clear();
      cyc(0, 0, 0, 0, 1);
      checks++; if ({ovf0, udf0} !== 2'b00) begin errors++; $display("FAIL clr_err: got ovf=%b udf=%b expected 0 0", ovf0, udf0); end
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 4'($urandom), 0, 0, 0);
      cyc(1, 4'h7, 0, 1, 0);
      checks++; if ({cnt0, empty0, rvld1} !== {CW'(0), 1'b1, 1'b0}) begin errors++; $display("FAIL flush_state: got count=%0d empty=%b fwft_vld=%b expected 0 1 0", cnt0, empty0, rvld1); end
      checks++; if ({ovf0, udf0} !== 2'b01) begin errors++; $display("FAIL flush_flags: got ovf=%b udf=%b expected 0 1", ovf0, udf0); end
      cyc(0, 0, 0, 0, 1);
      checks++; if ({ovf0, udf0} !== 2'b00) begin errors++; $display("FAIL clr_after_flush: got ovf=%b udf=%b expected 0 0", ovf0, udf0); end
      for (int i = 0; i < 5; i++) cyc(1, 4'($urandom), 0, 0, 0);
      cyc(1, 4'h3, 0, 0, 1);
      checks++; if ({ovf0, cnt0} !== {1'b1, CW'(5)}) begin errors++; $display("FAIL set_beats_clear: got ovf=%b count=%0d expected 1 5", ovf0, cnt0); end
      cyc(0, 0, 0, 1, 1);
   endtask

   task automatic test_fwft();
      cyc(1, 4'hA, 0, 0, 0);
      checks++; if ({rvld1, rdata1} !== {1'b1, 4'hA}) begin errors++; $display("FAIL fwft_show: got %b/%h expected 1/a", rvld1, rdata1); end
      checks++; if (rvld0 !== 1'b0) begin errors++; $display("FAIL std_no_read: got vld=%b expected 0", rvld0); end
      cyc(0, 0, 1, 0, 0);
      checks++; if ({empty1, rvld1} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got empty=%b vld=%b expected 1 0", empty1, rvld1); end
      checks++; if ({rvld0, rdata0} !== {1'b1, 4'hA}) begin errors++; $display("FAIL std_pop: got %b/%h expected 1/a", rvld0, rdata0); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 99) < 55), 4'($urandom), ($urandom_range(0, 99) < 45),
             ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 5));
         checks++; if (cnt0 !== CW'(q.size())) begin errors++; $display("FAIL rnd_count: cyc %0d got %0d expected %0d", n, cnt0, q.size()); end
         checks++; if ({full0, empty0, af0, ae0} !== {q.size() == DEPTH, q.size() == 0, q.size() >= AF, q.size() <= AE}) begin
            errors++; $display("FAIL rnd_flags: cyc %0d got f/e/af/ae=%b size %0d", n, {full0, empty0, af0, ae0}, q.size()); end
         checks++; if ({rvld0, rdata0} !== {m_rvalid, m_rdata}) begin errors++; $display("FAIL rnd_read: cyc %0d got %b/%h expected %b/%h", n, rvld0, rdata0, m_rvalid, m_rdata); end
         checks++; if ({ovf0, udf0, ovf1, udf1} !== {m_ovf, m_udf, m_ovf, m_udf}) begin errors++; $display("FAIL rnd_err: cyc %0d got %b expected ovf=%b udf=%b", n, {ovf0, udf0, ovf1, udf1}, m_ovf, m_udf); end
         checks++; if (rvld1 !== (q.size() > 0)) begin errors++; $display("FAIL rnd_fwft_vld: cyc %0d got %b expected %b", n, rvld1, q.size() > 0); end
         if (q.size() > 0) begin
            checks++; if (rdata1 !== q[0]) begin errors++; $display("FAIL rnd_fwft_data: cyc %0d got %h expected %h", n, rdata1, q[0]); end
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(0, 0, 0, 1, 1);
      cyc(1, 4'h2, 0, 0, 0);
      cyc(1, 4'h3, 0, 0, 0);
      wr_en = 1; wdata = 4'h4;
      #2 rst_n = 0;
      #1;
      checks++; if ({cnt0, empty0, cnt1} !== {CW'(0), 1'b1, CW'(0)}) begin errors++; $display("FAIL async_reset: got count=%0d empty=%b fwft_count=%0d expected 0 1 0", cnt0, empty0, cnt1); end
      @(posedge clk);
      @(negedge clk);
      wr_en = 0;
      rst_n = 1;
      model_reset();
      @(negedge clk);
      checks++; if ({cnt0, rvld1, rdata1} !== {CW'(0), 1'b0, 4'h0}) begin errors++; $display("FAIL post_reset: got count=%0d fwft vld=%b data=%h expected 0 0 0", cnt0, rvld1, rdata1); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_flush_clear();
      test_fwft();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
